// File: rtl/rx_demux_tagged.sv
// CCI-P receive demultiplexer: routes c0/c1 responses to sub-AFU ports by the tag in
// the upper mdata bits, clears that tag, and broadcasts MMIO requests. Latency is 2 clk.
package ccip_if_pkg;
  localparam int CCIP_CLDATA_WIDTH = 512;

  typedef enum logic [3:0] { eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4 } t_ccip_c0_rsp;
  typedef enum logic [3:0] { eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4 } t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  // MMIO requests reuse the c0 header bits with this layout.
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr           hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
    logic                         rspValid;
    logic                         mmioRdValid;
    logic                         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module rx_demux_tagged
  import ccip_if_pkg::*;
#(
  parameter int N_SUBAFUS = 3,
  parameter int TAG_BITS  = $clog2(N_SUBAFUS),
  parameter int TAG_LSB   = 16 - TAG_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_if_ccip_Rx                  in,
  output t_if_ccip_Rx [N_SUBAFUS-1:0]  out,
  output logic [15:0]                  err_drop_cnt,
  output logic                         err_sticky
);

  localparam logic [TAG_BITS:0] N_PORTS = (TAG_BITS + 1)'(N_SUBAFUS);

  logic [TAG_BITS-1:0]  idx0, idx1;
  t_if_ccip_Rx          rx_d, rx_q;
  logic [N_SUBAFUS-1:0] c0_sel_d, c0_sel_q, c1_sel_d, c1_sel_q;
  logic [1:0]           drop_d, drop_q;

  t_if_ccip_Rx [N_SUBAFUS-1:0] out_d, out_q;
  logic [16:0]                 cnt_sum;
  logic [15:0]                 err_cnt_d, err_cnt_q;
  logic                        sticky_d, sticky_q;

  // Stage 1 decode: both channels resolve their target port independently.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rx_d     = in;
    c0_sel_d = '0;
    c1_sel_d = '0;
    drop_d   = '0;
    idx0     = in.c0.hdr.mdata[TAG_LSB +: TAG_BITS];
    idx1     = in.c1.hdr.mdata[TAG_LSB +: TAG_BITS];

    if (in.c0.rspValid) begin
      if (in.c0.hdr.resp_type == eRSP_UMSG) begin
        c0_sel_d[0] = 1'b1;
      end else if ({1'b0, idx0} < N_PORTS) begin
        c0_sel_d[idx0] = 1'b1;
        rx_d.c0.hdr.mdata[TAG_LSB +: TAG_BITS] = '0;
      end else begin
        drop_d[0] = 1'b1;
      end
    end

    if (in.c1.rspValid) begin
      if ({1'b0, idx1} < N_PORTS) begin
        c1_sel_d[idx1] = 1'b1;
        rx_d.c1.hdr.mdata[TAG_LSB +: TAG_BITS] = '0;
      end else begin
        drop_d[1] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: payload registers are reset as well so outputs read all-zero during reset.
      rx_q             <= '0;
      rx_q.c0TxAlmFull <= 1'b1;
      rx_q.c1TxAlmFull <= 1'b1;
      c0_sel_q         <= '0;
      c1_sel_q         <= '0;
      drop_q           <= '0;
    end else begin
      rx_q     <= rx_d;
      c0_sel_q <= c0_sel_d;
      c1_sel_q <= c1_sel_d;
      drop_q   <= drop_d;
    end
  end

  // Stage 2: headers/data/MMIO/almFull broadcast; only the response valids are steered.
  always_comb begin
    for (int k = 0; k < N_SUBAFUS; k++) begin
      out_d[k]             = rx_q;
      out_d[k].c0.rspValid = c0_sel_q[k];
      out_d[k].c1.rspValid = c1_sel_q[k];
    end
    cnt_sum   = {1'b0, err_cnt_q} + 17'(drop_q[0]) + 17'(drop_q[1]);
    err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    sticky_d  = sticky_q | (|drop_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_SUBAFUS; k++) begin
        out_q[k]             <= '0;
        out_q[k].c0TxAlmFull <= 1'b1;
        out_q[k].c1TxAlmFull <= 1'b1;
      end
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign out          = out_q;
  assign err_drop_cnt = err_cnt_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_rx_demux_tagged.sv
// Scoreboard bench for rx_demux_tagged: the driver predicts each port event and status
// word from the routing rules; a negedge monitor pops and compares what the ports show.
module tb_rx_demux_tagged;
  import ccip_if_pkg::*;

  localparam int N         = 3;
  localparam int TAG_LSB   = 14;
  localparam int TAG_SCALE = 2 ** TAG_LSB;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  t_if_ccip_Rx         in_rx;
  t_if_ccip_Rx [N-1:0] out_rx;
  logic [15:0]         err_drop_cnt;
  logic                err_sticky;
  int                  cyc = 0;

  rx_demux_tagged #(.N_SUBAFUS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in_rx),
    .out          (out_rx),
    .err_drop_cnt (err_drop_cnt),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 c0 response, 1 MMIO read, 2 MMIO write, 3 c1 response
  typedef struct {
    int           due;
    int           port;
    int           kind;
    logic [27:0]  hdr;
    logic [511:0] data;
  } t_ev;

  typedef struct {
    int          due;
    logic        a0;
    logic        a1;
    logic [15:0] cnt;
    logic        sticky;
  } t_st;

  typedef struct packed {
    logic         c0v;
    logic         umsg;
    logic [15:0]  m0;
    logic [511:0] d0;
    logic         c1v;
    logic         fence;
    logic [15:0]  m1;
    logic         mrd;
    logic         mwr;
    logic [15:0]  maddr;
    logic         a0;
    logic         a1;
  } t_stim;

  t_ev  exp_q[$];
  t_st  st_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   model_cnt = 0;
  bit   model_sticky = 1'b0;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
  endtask

  function automatic logic [639:0] pack_ev(input t_ev e);
    return 640'({32'(e.due), 4'(e.kind), 4'(e.port), e.hdr, e.data});
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic t_stim idle_stim();
    t_stim s;
    s = '0;
    return s;
  endfunction

  // Applies one input cycle and records what each port and the status must show 2 clk later.
  task automatic drive(input t_stim s);
    t_if_ccip_Rx         r;
    t_ccip_c0_ReqMmioHdr mh;
    t_ccip_c0_RspMemHdr  h0;
    t_ccip_c1_RspMemHdr  h1;
    bit                  ev_v[N][4];
    logic [27:0]         ev_h[N][4];
    logic [511:0]        ev_d[N][4];
    int                  drops;
    int                  due;
    t_ev                 e;
    t_st                 st;

    due   = cyc + 2;
    drops = 0;
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 4; k++) begin
        ev_v[p][k] = 1'b0;
        ev_h[p][k] = '0;
        ev_d[p][k] = '0;
      end

    r = '0;
    r.c0TxAlmFull = s.a0;
    r.c1TxAlmFull = s.a1;
    r.c0.data     = s.d0;
    if (s.c0v) begin
      r.c0.hdr.resp_type = s.umsg ? eRSP_UMSG : eRSP_RDLINE;
      r.c0.hdr.cl_num    = 2'($urandom);
      r.c0.hdr.mdata     = s.m0;
      r.c0.rspValid      = 1'b1;
      h0 = r.c0.hdr;
      if (s.umsg) begin
        ev_v[0][0] = 1'b1; ev_h[0][0] = h0; ev_d[0][0] = s.d0;
      end else if (int'(s.m0) / TAG_SCALE < N) begin
        h0.mdata = 16'(int'(s.m0) % TAG_SCALE);
        ev_v[int'(s.m0) / TAG_SCALE][0] = 1'b1;
        ev_h[int'(s.m0) / TAG_SCALE][0] = h0;
        ev_d[int'(s.m0) / TAG_SCALE][0] = s.d0;
      end else begin
        drops++;
      end
    end else if (s.mrd || s.mwr) begin
      mh         = '0;
      mh.address = s.maddr;
      mh.tid     = 9'($urandom);
      r.c0.hdr   = t_ccip_c0_RspMemHdr'(mh);
      r.c0.mmioRdValid = s.mrd;
      r.c0.mmioWrValid = s.mwr;
      for (int p = 0; p < N; p++) begin
        ev_v[p][s.mrd ? 1 : 2] = 1'b1;
        ev_h[p][s.mrd ? 1 : 2] = r.c0.hdr;
        ev_d[p][s.mrd ? 1 : 2] = s.d0;
      end
    end

    if (s.c1v) begin
      r.c1.hdr.resp_type = s.fence ? eRSP_WRFENCE : eRSP_WRLINE;
      r.c1.hdr.mdata     = s.m1;
      r.c1.rspValid      = 1'b1;
      h1 = r.c1.hdr;
      if (int'(s.m1) / TAG_SCALE < N) begin
        h1.mdata = 16'(int'(s.m1) % TAG_SCALE);
        ev_v[int'(s.m1) / TAG_SCALE][3] = 1'b1;
        ev_h[int'(s.m1) / TAG_SCALE][3] = h1;
      end else begin
        drops++;
      end
    end

    for (int p = 0; p < N; p++)
      for (int k = 0; k < 4; k++)
        if (ev_v[p][k]) begin
          e.due = due; e.port = p; e.kind = k; e.hdr = ev_h[p][k]; e.data = ev_d[p][k];
          exp_q.push_back(e);
        end

    model_cnt    = (model_cnt + drops > 65535) ? 65535 : model_cnt + drops;
    model_sticky = model_sticky || (drops > 0);
    st.due = due; st.a0 = s.a0; st.a1 = s.a1; st.cnt = 16'(model_cnt); st.sticky = model_sticky;
    st_q.push_back(st);

    in_rx = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    in_rx = '0;
    reset = 1'b1;
    exp_q.delete();
    st_q.delete();
    model_cnt    = 0;
    model_sticky = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(idle_stim());
  endtask

  // Monitor: compares every valid the DUT presents against the scoreboard.
  initial begin
    t_ev         e, a;
    t_st         s;
    logic        v, any_v, all_a;
    logic [2:0]  a0s, a1s;
    forever begin
      @(negedge clk);
      if (reset) begin
        any_v = 1'b0;
        all_a = 1'b1;
        for (int p = 0; p < N; p++) begin
          any_v |= out_rx[p].c0.rspValid | out_rx[p].c0.mmioRdValid |
                   out_rx[p].c0.mmioWrValid | out_rx[p].c1.rspValid;
          all_a &= out_rx[p].c0TxAlmFull & out_rx[p].c1TxAlmFull;
        end
        check("reset_state", 640'({any_v, all_a, err_drop_cnt, err_sticky}),
              640'({1'b0, 1'b1, 16'h0000, 1'b0}));
      end else begin
        for (int p = 0; p < N; p++)
          for (int k = 0; k < 4; k++) begin
            case (k)
              0:       v = out_rx[p].c0.rspValid;
              1:       v = out_rx[p].c0.mmioRdValid;
              2:       v = out_rx[p].c0.mmioWrValid;
              default: v = out_rx[p].c1.rspValid;
            endcase
            if (v) begin
              a.due  = cyc; a.port = p; a.kind = k;
              a.hdr  = (k == 3) ? 28'(out_rx[p].c1.hdr) : 28'(out_rx[p].c0.hdr);
              a.data = (k == 3) ? 512'd0 : out_rx[p].c0.data;
              if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid cycle %0d: port %0d kind %0d got valid, expected none",
                         cyc, p, k);
              end else begin
                e = exp_q.pop_front();
                check("port_event", pack_ev(a), pack_ev(e));
              end
            end
          end
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          n_checks++;
          $display("FAIL missing_valid cycle %0d: port %0d kind %0d got nothing, expected valid (due %0d)",
                   cyc, e.port, e.kind, e.due);
        end
        while (st_q.size() > 0 && st_q[0].due < cyc) void'(st_q.pop_front());
        if (st_q.size() > 0 && st_q[0].due == cyc) begin
          s = st_q.pop_front();
          for (int p = 0; p < N; p++) begin
            a0s[p] = out_rx[p].c0TxAlmFull;
            a1s[p] = out_rx[p].c1TxAlmFull;
          end
          check("status", 640'({a0s, a1s, err_drop_cnt, err_sticky}),
                640'({{3{s.a0}}, {3{s.a1}}, s.cnt, s.sticky}));
        end
      end
    end
  end

  initial begin
    t_stim s;
    in_rx = '0;
    do_reset(3);

    // Single routed response, then c0/c1 to different ports in one cycle.
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'h8005; s.d0 = rand_data();
    drive(s);
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'h4001; s.d0 = rand_data();
    s.c1v = 1'b1; s.m1 = 16'h0007;
    drive(s);
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'h4002; s.c1v = 1'b1; s.m1 = 16'h4003; s.fence = 1'b1;
    drive(s);
    idle(3);

    // MMIO write broadcast, then a UMsg whose tag bits would be out of range.
    s = idle_stim(); s.mwr = 1'b1; s.maddr = 16'h0010; s.d0 = 512'hDEAD;
    drive(s);
    s = idle_stim(); s.mrd = 1'b1; s.maddr = 16'h0024;
    drive(s);
    s = idle_stim(); s.c0v = 1'b1; s.umsg = 1'b1; s.m0 = 16'hC123; s.d0 = rand_data();
    drive(s);
    idle(3);

    // Back-to-back responses with rotating index while c1TxAlmFull toggles.
    for (int i = 0; i < 20; i++) begin
      s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'((i % 3) * TAG_SCALE + i); s.d0 = rand_data();
      s.a1 = i[1];
      drive(s);
    end
    idle(3);

    // Random traffic against the reference rules.
    for (int i = 0; i < 1500; i++) begin
      s = idle_stim();
      s.c0v = ($urandom_range(0, 3) != 0);
      s.umsg = s.c0v && ($urandom_range(0, 7) == 0);
      s.m0 = 16'($urandom);
      s.d0 = rand_data();
      if (!s.c0v && $urandom_range(0, 1) == 1) begin
        s.mrd = $urandom_range(0, 1) == 1;
        s.mwr = !s.mrd;
        s.maddr = 16'($urandom);
      end
      s.c1v = $urandom_range(0, 1) == 1;
      s.fence = $urandom_range(0, 1) == 1;
      s.m1 = 16'($urandom);
      s.a0 = $urandom_range(0, 1) == 1;
      s.a1 = $urandom_range(0, 1) == 1;
      drive(s);
    end
    idle(3);

    // Double drop in one cycle, then saturate the drop counter.
    do_reset(2);
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'hC000; s.c1v = 1'b1; s.m1 = 16'hC001;
    drive(s);
    idle(3);
    for (int i = 0; i < 32770; i++) begin
      s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'hC000 | 16'($urandom_range(0, 255));
      s.c1v = 1'b1; s.m1 = 16'hC000 | 16'($urandom_range(0, 255));
      drive(s);
    end
    idle(3);

    // Reset with responses in flight: nothing may emerge until new input arrives.
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'h4011; s.d0 = rand_data();
    drive(s);
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'h8012; s.d0 = rand_data();
    drive(s);
    do_reset(2);
    idle(5);
    s = idle_stim(); s.c0v = 1'b1; s.m0 = 16'h0013; s.d0 = rand_data(); s.a0 = 1'b1;
    drive(s);
    idle(4);

    check("scoreboard_drained", 640'(exp_q.size()), 640'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
